// File: rtl/cnt_tours_pkg.sv
// Shared definitions for the lap counters: FSM encodings and default sizing.
package cnt_tours_pkg;

  localparam int DEF_BUS_SIZE        = 4;
  localparam int DEF_MAX_LAPS        = 9;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lap_edge_sync.sv
// Lap sensor front end: 2-flop synchroniser, registered rising-edge event and,
// with CNT_TOURS_DOWN_DEBOUNCE_EN defined, a hold-off counter after each event.
module lap_edge_sync #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic nReset,
  input  logic clear,
  input  logic lap_in,
  output logic lap_evt
);

  logic sync_1;
  logic sync_2;
  logic sync_3;
  logic rise;

  assign rise = sync_2 & ~sync_3;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= lap_in;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

`ifdef CNT_TOURS_DOWN_DEBOUNCE_EN
  localparam int HW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [HW-1:0] hold;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      hold    <= '0;
      lap_evt <= 1'b0;
    end else if (clear) begin
      hold    <= '0;
      lap_evt <= 1'b0;
    end else if (rise && hold == '0) begin
      hold    <= HW'(DEBOUNCE_CYCLES);
      lap_evt <= 1'b1;
    end else begin
      lap_evt <= 1'b0;
      if (hold != '0) hold <= hold - HW'(1);
    end
  end
`else
  // No hold-off in this build; the parameter only qualifies the edge path.
  localparam logic EDGE_EN = (DEBOUNCE_CYCLES >= 0);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) lap_evt <= 1'b0;
    else         lap_evt <= EDGE_EN & rise & ~clear;
  end
`endif

endmodule

// File: rtl/cnt_tours_down.sv
// Race lap countdown: load a target, decrement per lap event, flag last lap / done.
// Optional lap hold-off enabled by defining CNT_TOURS_DOWN_DEBOUNCE_EN.
module cnt_tours_down
  import cnt_tours_pkg::*;
#(
  parameter int BUS_SIZE        = DEF_BUS_SIZE,
  parameter int MAX_LAPS        = DEF_MAX_LAPS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                load,
  input  logic [BUS_SIZE-1:0] target,
  input  logic                abort,
  input  logic                lap_in,
  output logic [BUS_SIZE-1:0] remaining,
  output logic                running,
  output logic                last_lap,
  output logic                finished,
  output logic                done_pulse,
  output logic [1:0]          fsm_state
);

  localparam logic [BUS_SIZE-1:0] MAX_V = BUS_SIZE'(MAX_LAPS);

  state_t              state;
  logic                lap_evt;
  logic [BUS_SIZE-1:0] eff;

  assign eff = (target > MAX_V) ? MAX_V : target;

  lap_edge_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_lap_edge_sync (
    .clk    (clk),
    .nReset (nReset),
    .clear  (abort | load),
    .lap_in (lap_in),
    .lap_evt(lap_evt)
  );

  // Priority: abort, then load, then lap event (only counted in RUN).
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        remaining <= '0;
      end else if (load) begin
        if (eff != '0) begin
          state     <= ST_RUN;
          remaining <= eff;
        end else begin
          state      <= ST_DONE;
          remaining  <= '0;
          done_pulse <= 1'b1;
        end
      end else begin
        case (state)
          ST_RUN: begin
            if (lap_evt) begin
              if (remaining <= BUS_SIZE'(1)) begin
                state      <= ST_DONE;
                remaining  <= '0;
                done_pulse <= 1'b1;
              end else begin
                remaining <= remaining - BUS_SIZE'(1);
              end
            end
          end
          ST_DONE: state <= ST_DONE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign running   = (state == ST_RUN);
  assign finished  = (state == ST_DONE);
  assign last_lap  = (state == ST_RUN) && (remaining == BUS_SIZE'(1));
  assign fsm_state = state;

endmodule
